// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: registered 10b->8b and control-token decode, plus word
// alignment that hunts for runs of control tokens and requests deserializer slips.
module tmds_channel_decoder #(
    parameter int MIN_CTRL_RUN = 12,
    parameter int LOCK_PERIODS = 2,
    parameter int WINDOW_BITS  = 16,
    parameter int SLIP_SETTLE  = 4
) (
    input  logic       pixelClock,
    input  logic       reset,
    input  logic [9:0] symbol,
    output logic [7:0] data,
    output logic       c0,
    output logic       c1,
    output logic       dataEnable,
    output logic       isControl,
    output logic       locked,
    output logic       bitSlip,
    output logic [1:0] align_state
);
    localparam int RW = $clog2(MIN_CTRL_RUN + 1);
    localparam int PW = (LOCK_PERIODS > 1) ? $clog2(LOCK_PERIODS) : 1;
    localparam int SW = (SLIP_SETTLE > 1) ? $clog2(SLIP_SETTLE) : 1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SETTLE = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } align_t;

    align_t                 state, state_next;
    logic [RW-1:0]          run_count, run_next;
    logic [PW-1:0]          period_count, period_next;
    logic [SW-1:0]          settle_count, settle_next;
    logic [WINDOW_BITS-1:0] win_count, win_next;
    logic                   slip_req;
    logic                   is_ctrl;
    logic [1:0]             ctrl_bits;
    logic [7:0]             t;
    logic [7:0]             dec;
    logic                   qualified;
    logic                   expiry;

    always_comb begin
        is_ctrl   = 1'b1;
        ctrl_bits = 2'b00;
        case (symbol)
            10'h354: ctrl_bits = 2'b00;
            10'h0AB: ctrl_bits = 2'b01;
            10'h154: ctrl_bits = 2'b10;
            10'h2AB: ctrl_bits = 2'b11;
            default: is_ctrl = 1'b0;
        endcase
        t      = symbol[9] ? ~symbol[7:0] : symbol[7:0];
        dec    = 8'h00;
        dec[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = symbol[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
    end

    // The run counter saturates, so a long blanking period qualifies only once.
    always_comb begin
        run_next = '0;
        if (state != SETTLE && is_ctrl) begin
            if (run_count == RW'(MIN_CTRL_RUN)) run_next = run_count;
            else                                run_next = run_count + RW'(1);
        end
        qualified = (state != SETTLE) && is_ctrl && (run_count == RW'(MIN_CTRL_RUN - 1));
        expiry    = (win_count == '1);
    end

    // A qualified period always takes priority over a window expiry.
    always_comb begin
        state_next   = state;
        period_next  = period_count;
        settle_next  = settle_count;
        slip_req     = 1'b0;
        case (state)
            SEARCH: begin
                if (qualified) begin
                    state_next  = VERIFY;
                    period_next = '0;
                end else if (expiry) begin
                    state_next  = SETTLE;
                    settle_next = '0;
                    slip_req    = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_count == SW'(SLIP_SETTLE - 1)) state_next = SEARCH;
                else settle_next = settle_count + SW'(1);
            end
            VERIFY: begin
                if (qualified) begin
                    if (period_count == PW'(LOCK_PERIODS - 1)) state_next = LOCKED;
                    else period_next = period_count + PW'(1);
                end else if (expiry) begin
                    state_next  = SETTLE;
                    settle_next = '0;
                    slip_req    = 1'b1;
                end
            end
            LOCKED: begin
                if (!qualified && expiry) state_next = SEARCH;
            end
            default: state_next = SEARCH;
        endcase
        win_next = (qualified || state_next != state) ? '0 : win_count + WINDOW_BITS'(1);
    end

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            state        <= SEARCH;
            run_count    <= '0;
            period_count <= '0;
            settle_count <= '0;
            win_count    <= '0;
            data         <= '0;
            c0           <= 1'b0;
            c1           <= 1'b0;
            dataEnable   <= 1'b0;
            isControl    <= 1'b0;
            bitSlip      <= 1'b0;
        end else begin
            state        <= state_next;
            run_count    <= run_next;
            period_count <= period_next;
            settle_count <= settle_next;
            win_count    <= win_next;
            data         <= is_ctrl ? 8'h00 : dec;
            isControl    <= is_ctrl;
            if (is_ctrl) begin
                c1 <= ctrl_bits[1];
                c0 <= ctrl_bits[0];
            end
            dataEnable   <= (state_next == LOCKED) && !is_ctrl;
            bitSlip      <= slip_req;
        end
    end

    assign locked      = (state == LOCKED);
    assign align_state = state;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: decode table, byte sweep, lock, loss of
// lock, mid-VERIFY reset and slip-driven realignment of a rotated stream.
module tb_tmds_channel_decoder;
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    logic       pixelClock = 1'b0;
    logic       reset      = 1'b1;
    logic [9:0] symbol     = 10'h000;
    logic [7:0] data;
    logic       c0, c1, dataEnable, isControl, locked, bitSlip;
    logic [1:0] align_state;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    tmds_channel_decoder #(
        .MIN_CTRL_RUN(12),
        .LOCK_PERIODS(2),
        .WINDOW_BITS (8),
        .SLIP_SETTLE (4)
    ) dut (
        .pixelClock (pixelClock),
        .reset      (reset),
        .symbol     (symbol),
        .data       (data),
        .c0         (c0),
        .c1         (c1),
        .dataEnable (dataEnable),
        .isControl  (isControl),
        .locked     (locked),
        .bitSlip    (bitSlip),
        .align_state(align_state)
    );

    always #5 pixelClock = ~pixelClock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [9:0] w);
        symbol = w;
        @(posedge pixelClock);
        @(negedge pixelClock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(10'h000);
        step(10'h000);
        reset = 1'b0;
    endtask

    task automatic burst();
        for (int k = 0; k < 12; k++) step(10'h354);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_data"}, {24'h0, data}, 32'h0);
        check_val({tag, "_c1c0"}, {30'h0, c1, c0}, 32'h0);
        check_val({tag, "_de"}, {31'h0, dataEnable}, 32'h0);
        check_val({tag, "_isctl"}, {31'h0, isControl}, 32'h0);
        check_val({tag, "_locked"}, {31'h0, locked}, 32'h0);
        check_val({tag, "_slip"}, {31'h0, bitSlip}, 32'h0);
        check_val({tag, "_state"}, {30'h0, align_state}, {30'h0, ST_SEARCH});
    endtask

    // Reference TMDS transmitter for one data byte; inv picks the disparity branch.
    function automatic logic [9:0] tmds_enc(input logic [7:0] d, input logic inv);
        logic [8:0] q;
        int n1;
        n1   = $countones(d);
        q    = '0;
        q[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
            q[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
            q[8] = 1'b1;
        end
        return {inv, q[8], inv ? ~q[7:0] : q[7:0]};
    endfunction

    function automatic logic [9:0] pat(input int i);
        return ((i % 112) < 12) ? 10'h354 : 10'h1F0;
    endfunction

    initial begin
        logic [9:0] tokens [4];
        logic [9:0] rx;
        logic [19:0] pair;
        int slips, offset, idx, cyc, last_slip;

        tokens[0] = 10'h354; tokens[1] = 10'h0AB; tokens[2] = 10'h154; tokens[3] = 10'h2AB;

        // reset state
        do_reset();
        check_zero("reset");

        // control tokens
        for (int k = 0; k < 4; k++) begin
            step(tokens[k]);
            check_val("ctl_c1c0", {30'h0, c1, c0}, k);
            check_val("ctl_isctl", {31'h0, isControl}, 32'h1);
            check_val("ctl_data", {24'h0, data}, 32'h0);
        end

        // fixed data words; C1:C0 must hold the last token's value
        step(10'h100);
        check_val("d100_data", {24'h0, data}, 32'h00);
        check_val("d100_isctl", {31'h0, isControl}, 32'h0);
        check_val("d100_hold", {30'h0, c1, c0}, 32'h3);
        check_val("d100_de", {31'h0, dataEnable}, 32'h0);
        step(10'h200);
        check_val("d200_data", {24'h0, data}, 32'hFF);

        // all bytes through the reference encoder
        for (int b = 0; b < 256; b++) begin
            exp_q.push_back(8'(b));
            step(tmds_enc(8'(b), 1'($urandom_range(0, 1))));
            check_val("sweep", {24'h0, data}, {24'h0, exp_q.pop_front()});
        end

        // lock sequence
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 12; k++) begin
                step(10'h354);
                if (p == 2 && k == 10) check_val("lock_pre", {31'h0, locked}, 32'h0);
            end
            check_val("lock_state", {30'h0, align_state}, (p < 2) ? {30'h0, ST_VERIFY} : {30'h0, ST_LOCKED});
            check_val("lock_flag", {31'h0, locked}, (p < 2) ? 32'h0 : 32'h1);
            if (p < 2) for (int k = 0; k < 100; k++) step(10'h100);
        end
        check_val("lock_de_ctl", {31'h0, dataEnable}, 32'h0);

        // loss of lock: data only from the last qualified period onward
        slips = 0;
        for (int k = 1; k < 256; k++) begin
            step(10'h100);
            if (k == 1) check_val("locked_de", {31'h0, dataEnable}, 32'h1);
            slips += bitSlip;
        end
        check_val("lol_still_locked", {31'h0, locked}, 32'h1);
        step(10'h100);
        check_val("lol_locked", {31'h0, locked}, 32'h0);
        check_val("lol_de", {31'h0, dataEnable}, 32'h0);
        check_val("lol_state", {30'h0, align_state}, {30'h0, ST_SEARCH});
        for (int k = 1; k < 256; k++) begin
            step(10'h100);
            slips += bitSlip;
        end
        check_val("lol_no_slip", slips, 32'h0);
        step(10'h100);
        check_val("lol_slip", {31'h0, bitSlip}, 32'h1);
        step(10'h100);
        check_val("lol_slip_1cyc", {31'h0, bitSlip}, 32'h0);

        // reset while in VERIFY
        do_reset();
        burst();
        check_val("rv_verify", {30'h0, align_state}, {30'h0, ST_VERIFY});
        for (int k = 0; k < 20; k++) step(10'h100);
        reset = 1'b1;
        step(10'h100);
        reset = 1'b0;
        check_zero("rv_reset");
        for (int p = 0; p < 3; p++) begin
            burst();
            check_val("rv_relock", {31'h0, locked}, (p < 2) ? 32'h0 : 32'h1);
            for (int k = 0; k < 100; k++) step(10'h100);
        end

        // misaligned stream: model shifts its bit window on each slip
        do_reset();
        offset = 3; idx = 0; cyc = 0; slips = 0; last_slip = 0;
        while (cyc < 5000 && !locked) begin
            pair = {pat(idx + 1), pat(idx)};
            rx   = pair[offset +: 10];
            step(rx);
            idx++; cyc++;
            if (bitSlip) begin
                check_val("mis_slip_time", cyc, (slips == 0) ? 256 : last_slip + 260);
                last_slip = cyc;
                slips++;
                offset = (offset + 1) % 10;
            end
        end
        check_val("mis_locked", {31'h0, locked}, 32'h1);
        check_val("mis_slips", slips, 32'd7);
        check_val("mis_offset", offset, 32'd0);
        slips = 0;
        for (int k = 0; k < 600; k++) begin
            pair = {pat(idx + 1), pat(idx)};
            rx   = pair[offset +: 10];
            step(rx);
            idx++;
            slips += bitSlip;
        end
        check_val("mis_no_more_slips", slips, 32'h0);
        check_val("mis_stays_locked", {31'h0, locked}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
